// File: rtl/s2p_sched_pkg.sv
// Shared types and defaults for the serial-to-parallel frame scheduler.
package s2p_sched_pkg;

    localparam int N_LANES_DEF    = 4;
    localparam int FRAME_BITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } sched_state_t;

    // Single-step modular wrap; callers never exceed 2*n-1.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/s2p_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after ptr, with wrap.
module s2p_rr_arbiter
    import s2p_sched_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int LW      = $clog2(N_LANES)
) (
    input  logic [N_LANES-1:0] req,
    input  logic [LW-1:0]      ptr,
    output logic [N_LANES-1:0] gnt,
    output logic [LW-1:0]      idx,
    output logic               any
);

    logic [LW-1:0] cand_s;
    logic          hit_s;

    // Scan lanes in rotation order; only the first hit may set a grant bit.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            cand_s      = LW'(rr_wrap(int'(ptr) + i, N_LANES));
            hit_s       = req[cand_s] & ~any;
            gnt[cand_s] = gnt[cand_s] | hit_s;
            idx         = hit_s ? cand_s : idx;
            any         = any | hit_s;
        end
    end

endmodule

// File: rtl/s2p_frame_scheduler.sv
// Serial-to-parallel frame scheduler: grants one lane at a time round-robin and
// assembles FRAME_BITS LSB-first serial bits from it into a parallel frame.
module s2p_frame_scheduler
    import s2p_sched_pkg::*;
#(
    parameter int N_LANES    = N_LANES_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_LANES-1:0]         req_i,
    input  logic [N_LANES-1:0]         serial_i,
    input  logic [N_LANES-1:0]         valid_i,
    output logic [N_LANES-1:0]         gnt_o,
    output logic [FRAME_BITS-1:0]      data_o,
    output logic [$clog2(N_LANES)-1:0] lane_o,
    output logic                       valid_o,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int            LW       = $clog2(N_LANES);
    localparam int            CW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(N_LANES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

    sched_state_t          state_r;
    logic [N_LANES-1:0]    gnt_r;
    logic [LW-1:0]         cur_lane_r;
    logic [LW-1:0]         last_lane_r;
    logic [CW-1:0]         cnt_r;
    logic [FRAME_BITS-1:0] shreg_r;
    logic [FRAME_BITS-1:0] data_r;
    logic [LW-1:0]         lane_r;
    logic                  valid_r;
    logic                  err_r;
    logic                  busy_r;

    logic [LW-1:0]         ptr_s;
    logic [N_LANES-1:0]    win_gnt_s;
    logic [LW-1:0]         win_idx_s;
    logic                  win_any_s;
    logic                  accept_s;
    logic                  final_s;
    logic                  req_held_s;

    assign ptr_s      = (last_lane_r == LAST_IDX) ? {LW{1'b0}} : (last_lane_r + LW'(1));
    assign accept_s   = valid_i[cur_lane_r];
    assign req_held_s = req_i[cur_lane_r];
    assign final_s    = accept_s && (cnt_r == CNT_LAST);

    s2p_rr_arbiter #(
        .N_LANES (N_LANES),
        .LW      (LW)
    ) u_arb (
        .req (req_i),
        .ptr (ptr_s),
        .gnt (win_gnt_s),
        .idx (win_idx_s),
        .any (win_any_s)
    );

    // Frame FSM with all datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            gnt_r       <= '0;
            cur_lane_r  <= '0;
            last_lane_r <= LAST_IDX;
            cnt_r       <= '0;
            shreg_r     <= '0;
            data_r      <= '0;
            lane_r      <= '0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_any_s) begin
                        gnt_r      <= win_gnt_s;
                        cur_lane_r <= win_idx_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // A final bit arriving with the req drop still completes the frame.
                    if (final_s) begin
                        shreg_r <= {serial_i[cur_lane_r], shreg_r[FRAME_BITS-1:1]};
                        cnt_r   <= '0;
                        gnt_r   <= '0;
                        state_r <= ST_DONE;
                    end else if (!req_held_s) begin
                        shreg_r <= '0;
                        cnt_r   <= '0;
                        gnt_r   <= '0;
                        state_r <= ST_ABORT;
                    end else if (accept_s) begin
                        shreg_r <= {serial_i[cur_lane_r], shreg_r[FRAME_BITS-1:1]};
                        cnt_r   <= cnt_r + CW'(1);
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_DONE: begin
                    valid_r     <= 1'b1;
                    data_r      <= shreg_r;
                    lane_r      <= cur_lane_r;
                    last_lane_r <= cur_lane_r;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                ST_ABORT: begin
                    err_r       <= 1'b1;
                    last_lane_r <= cur_lane_r;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_r;
    assign data_o  = data_r;
    assign lane_o  = lane_r;
    assign valid_o = valid_r;
    assign err_o   = err_r;
    assign busy_o  = busy_r;

endmodule

// File: tb/tb_s2p_frame_scheduler.sv
// Self-checking bench for s2p_frame_scheduler: directed scenarios plus random
// frames checked against a round-robin / frame-assembly reference model.
module tb_s2p_frame_scheduler;

    localparam int NL = 4;
    localparam int FB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] req;
    logic [NL-1:0] serial;
    logic [NL-1:0] valid;
    logic [NL-1:0] gnt_o;
    logic [FB-1:0] data_o;
    logic [1:0]    lane_o;
    logic          valid_o;
    logic          err_o;
    logic          busy_o;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            t0;
    int            m_last;
    logic [FB-1:0] m_data;
    int            m_lane;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s2p_frame_scheduler #(.N_LANES(NL), .FRAME_BITS(FB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .serial_i (serial),
        .valid_i  (valid),
        .gnt_o    (gnt_o),
        .data_o   (data_o),
        .lane_o   (lane_o),
        .valid_o  (valid_o),
        .err_o    (err_o),
        .busy_o   (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: scan lanes last+1, last+2, ... modulo NL.
    function automatic int rr_pick(input logic [NL-1:0] r, input int last);
        int c;
        for (int k = 1; k <= NL; k++) begin
            c = (last + k) % NL;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NL - 1;
        m_data = '0;
        m_lane = 0;
    endtask

    // Serve one frame of the expected lane; mode 0 = strobe every cycle,
    // 1 = every other cycle, 2 = random. abort_after >= 0 drops req after that many bits.
    task automatic serve(input int lane, input logic [FB-1:0] bits, input int mode,
                         input int abort_after, input bit drop_last);
        int   acc;
        int   guard;
        int   wait_n;
        bit   early;
        logic v;
        wait_n = 0;
        while (gnt_o == '0 && wait_n < 8) begin
            tick();
            wait_n++;
        end
        chk("gnt_latency", 32'(wait_n), 32'd1);
        chk("gnt_onehot", 32'(gnt_o), 32'(1 << lane));
        chk("busy_in_frame", 32'(busy_o), 32'd1);
        acc   = 0;
        guard = 0;
        early = 1'b0;
        while (acc < FB && guard < 100 && acc != abort_after) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((guard % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            valid         = NL'($urandom);
            serial        = NL'($urandom);
            valid[lane]   = v;
            serial[lane]  = bits[acc];
            if (drop_last && v && acc == FB - 1) req[lane] = 1'b0;
            tick();
            if (valid_o || err_o) early = 1'b1;
            if (v) acc++;
            guard++;
        end
        chk("no_early_pulse", 32'(early), 32'd0);
        valid[lane] = 1'b0;
        req[lane]   = 1'b0;
        if (acc == abort_after) begin
            tick();
            tick();
            chk("abort_err", 32'(err_o), 32'd1);
            chk("abort_no_valid", 32'(valid_o), 32'd0);
            chk("abort_data_hold", 32'(data_o), 32'(m_data));
            chk("abort_lane_hold", 32'(lane_o), 32'(m_lane));
            chk("abort_busy", 32'(busy_o), 32'd0);
            m_last = lane;
        end else begin
            chk("shift_bound", 32'(acc), 32'(FB));
            chk("done_gnt_clear", 32'(gnt_o), 32'd0);
            tick();
            chk("done_valid", 32'(valid_o), 32'd1);
            chk("done_data", 32'(data_o), 32'(bits));
            chk("done_lane", 32'(lane_o), 32'(lane));
            chk("done_no_err", 32'(err_o), 32'd0);
            m_last = lane;
            m_data = bits;
            m_lane = lane;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        valid  = '0;
        serial = '0;
        tick();
        rst_n  = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        int            e;
        int            ab;
        logic [NL-1:0] r;
        rst_n  = 1'b0;
        req    = '0;
        serial = '0;
        valid  = '0;
        model_reset();
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_lane", 32'(lane_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Lane 2 alone, bits 1,0,1,1,0,0,1,0 on consecutive cycles.
        req[2] = 1'b1;
        t0 = cyc;
        serve(2, 8'h4D, 0, -1, 1'b0);
        chk("latency_req_to_valid", 32'(cyc - t0), 32'd10);

        // Lone requester is re-granted after a single idle cycle.
        req[2] = 1'b1;
        serve(2, 8'hA5, 0, -1, 1'b0);

        // All lanes request after reset: 0,1,2,3 then 0 again.
        do_reset();
        req = 4'b1111;
        serve(0, 8'h11, 0, -1, 1'b0);
        req[0] = 1'b1;
        serve(1, 8'h22, 0, -1, 1'b0);
        serve(2, 8'h33, 0, -1, 1'b0);
        serve(3, 8'h44, 0, -1, 1'b0);
        serve(0, 8'h55, 0, -1, 1'b0);

        // Lane 1 with strobes on alternate cycles.
        req = 4'b0010;
        serve(1, 8'hC3, 1, -1, 1'b0);

        // Lane 3 aborts after 5 bits; lane 0 wins next.
        req = 4'b1000;
        serve(3, 8'hFF, 0, 5, 1'b0);
        req = 4'b1001;
        serve(0, 8'h5A, 0, -1, 1'b0);
        serve(3, 8'h96, 0, -1, 1'b0);

        // Lane 0 drops req in the same cycle as its last bit.
        req = 4'b0001;
        serve(0, 8'h3C, 0, -1, 1'b1);

        // Reset in the middle of a frame.
        req = 4'b0010;
        e = rr_pick(req, m_last);
        tick();
        chk("midrst_gnt", 32'(gnt_o), 32'(1 << e));
        for (int k = 0; k < 4; k++) begin
            valid[e]  = 1'b1;
            serial[e] = 1'(k & 1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt_zero", 32'(gnt_o), 32'd0);
        chk("midrst_data_zero", 32'(data_o), 32'd0);
        chk("midrst_lane_zero", 32'(lane_o), 32'd0);
        chk("midrst_valid_zero", 32'(valid_o), 32'd0);
        chk("midrst_busy_zero", 32'(busy_o), 32'd0);
        tick();
        chk("midrst_no_err", 32'(err_o), 32'd0);
        req   = '0;
        valid = '0;
        rst_n = 1'b1;
        model_reset();
        tick();
        req = 4'b0101;
        serve(0, 8'h81, 0, -1, 1'b0);
        serve(2, 8'h7E, 0, -1, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 24; n++) begin
            r = NL'($urandom_range(1, (1 << NL) - 1));
            req = r;
            e  = rr_pick(r, m_last);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FB - 1)) : -1;
            serve(e, FB'($urandom), 2, ab, 1'($urandom_range(0, 1)));
        end

        req   = '0;
        valid = '0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/s2p_frame_scheduler.md
S2P_FRAME_SCHEDULER -- requirements
Module: s2p_frame_scheduler

Interface
REQ-001 SHALL have parameter N_LANES, default 4, number of serial requester lanes (2..8).
REQ-002 SHALL have parameter FRAME_BITS, default 8, bits per frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  N_LANES  per-lane frame request, level, held high until frame ends.
REQ-006 SHALL have port serial_i  input  N_LANES  per-lane serial data bit.
REQ-007 SHALL have port valid_i  input  N_LANES  per-lane bit-valid strobe.
REQ-008 SHALL have port gnt_o  output  N_LANES  one-hot grant; all-zero when no lane is granted.
REQ-009 SHALL have port data_o  output  FRAME_BITS  assembled frame, LSB = first bit received.
REQ-010 SHALL have port lane_o  output  $clog2(N_LANES)  index of the lane that sourced data_o.
REQ-011 SHALL have port valid_o  output  1  one-cycle pulse, data_o/lane_o valid.
REQ-012 SHALL have port err_o  output  1  one-cycle pulse, frame aborted.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE, ABORT.
REQ-015 IDLE: if any req_i bit is high, SHALL select the winner round-robin, starting the search at (last_lane+1) mod N_LANES, register its one-hot gnt_o, and enter SHIFT on the next edge.
REQ-016 SHIFT: SHALL accept a bit only when valid_i[granted] is high; serial_i/valid_i of non-granted lanes SHALL be ignored.
REQ-017 Each accepted bit SHALL shift in LSB-first: shreg <= {bit, shreg[FRAME_BITS-1:1]}; bit counter increments by 1.
REQ-018 On acceptance of bit FRAME_BITS, SHALL enter DONE; the counter SHALL wrap to 0.
REQ-019 DONE, one cycle: valid_o=1, data_o=shreg, lane_o=granted index, gnt_o=0, last_lane=granted; then IDLE.
REQ-020 Latency: valid_o SHALL assert exactly 1 cycle after the edge that accepts the final bit; minimum frame = FRAME_BITS+2 cycles from req to valid_o.
REQ-021 SHIFT with req_i[granted] low and no final-bit acceptance: SHALL enter ABORT, discard shreg, and clear the counter.
REQ-022 ABORT, one cycle: err_o=1, gnt_o=0, valid_o=0, last_lane=granted; then IDLE.
REQ-023 Simultaneous req drop and final-bit acceptance: the final bit SHALL be accepted and the frame SHALL complete (DONE, no err_o).
REQ-024 data_o and lane_o SHALL hold their last values until the next DONE; they SHALL NOT be altered by ABORT.
REQ-025 Round-robin pointer SHALL wrap from N_LANES-1 to 0; a lone requester SHALL be granted back-to-back, with one IDLE cycle between frames.
REQ-026 A lane SHALL NOT be re-granted while any other lane requests, unless the pointer rotation reaches it.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, gnt_o=0, data_o=0, lane_o=0, valid_o=0, err_o=0, busy_o=0, counter=0, shreg=0, last_lane=N_LANES-1.
REQ-028 Reset mid-frame SHALL drop the frame silently (no err_o); after release, arbitration SHALL restart from lane 0.

Structure
REQ-029 Package s2p_sched_pkg SHALL hold the FSM state enum typedef and default constants N_LANES_DEF=4, FRAME_BITS_DEF=8.
REQ-030 Round-robin selection SHALL be one sub-module, s2p_rr_arbiter (inputs: req vector, pointer; output: one-hot winner plus index), purely combinational.
REQ-031 All state, counter, shift and output registers SHALL reside in s2p_frame_scheduler.

Verification
REQ-032 Lane 2 alone requests and sends bits 1,0,1,1,0,0,1,0 on consecutive cycles -> gnt_o=4'b0100, valid_o pulse with data_o=8'h4D, lane_o=2, 10 cycles after req.
REQ-033 Lanes 0-3 request simultaneously after reset -> grants in order 0,1,2,3,0; each valid_o carries the matching lane_o.
REQ-034 Lane 1 granted, valid_i toggles every other cycle -> only strobed bits are captured; valid_o follows the 8th strobed bit by 1 cycle.
REQ-035 Lane 3 drops req after 5 bits -> err_o pulse, no valid_o, data_o unchanged, next grant goes to lane 0 if it requests.
REQ-036 rst_n asserted after 4 bits of a frame -> all outputs 0 the same cycle, no err_o; after release, lane 0 and lane 2 requesting -> lane 0 granted first.
REQ-037 Lane 0 drops req in the cycle of its 8th accepted bit -> valid_o pulses, err_o stays 0.
